snake_state_engine: RTL and testbench



---
 rtl/snake_state_engine.sv | 217 +++++++++++++++++++++
 tb/tb_snake_state_engine.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_state_engine.sv
// Snake game-state writer: owns the body ring buffer, occupancy vector, apple
// and game status, and advances the snake one tile per move_tick.
module snake_state_engine #(
  parameter int unsigned GRID_SIZE = 15,
  parameter int unsigned NUM_CELLS = GRID_SIZE * GRID_SIZE,
  parameter int unsigned START_X   = 7,
  parameter int unsigned START_Y   = 7,
  parameter int unsigned APPLE0_X  = 10,
  parameter int unsigned APPLE0_Y  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 move_tick,
  input  logic                 start,
  input  logic                 up,
  input  logic                 down,
  input  logic                 left,
  input  logic                 right,
  output logic [3:0]           Head_X,
  output logic [3:0]           Head_Y,
  output logic [3:0]           Tail_X,
  output logic [3:0]           Tail_Y,
  output logic [3:0]           Apple_X,
  output logic [3:0]           Apple_Y,
  output logic [NUM_CELLS-1:0] Cell_Snake_Vector,
  output logic [7:0]           score,
  output logic                 game_over,
  output logic                 win,
  output logic                 busy
);

  localparam int unsigned CW = 8;
  localparam int unsigned PW = 4;

  localparam logic [2:0] S_INIT0  = 3'd0;
  localparam logic [2:0] S_INIT1  = 3'd1;
  localparam logic [2:0] S_IDLE   = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_STEP   = 3'd4;
  localparam logic [2:0] S_TAILRD = 3'd5;
  localparam logic [2:0] S_PLACE  = 3'd6;
  localparam logic [2:0] S_OVER   = 3'd7;

  // Opposite directions differ only in bit 0.
  localparam logic [1:0] D_RIGHT = 2'd0;
  localparam logic [1:0] D_LEFT  = 2'd1;
  localparam logic [1:0] D_UP    = 2'd2;
  localparam logic [1:0] D_DOWN  = 2'd3;

  localparam logic [CW-1:0] HEAD0_IDX = CW'(START_X * GRID_SIZE + START_Y);
  localparam logic [CW-1:0] TAIL0_IDX = CW'((START_X - 1) * GRID_SIZE + START_Y);
  localparam logic [CW-1:0] LAST_IDX  = CW'(NUM_CELLS - 1);
  localparam logic [PW-1:0] LAST_XY   = PW'(GRID_SIZE - 1);
  localparam logic [NUM_CELLS-1:0] VEC0 =
    (NUM_CELLS'(1) << HEAD0_IDX) | (NUM_CELLS'(1) << TAIL0_IDX);

  logic [2:0]    r_state, w_state_nx;
  logic [CW-1:0] r_buf [0:NUM_CELLS-1];
  logic [CW-1:0] r_head_ptr, r_tail_ptr, r_len, r_cand, r_place_cnt, r_lfsr;
  logic [1:0]    r_dir, r_pend;

  logic          w_soft_rst, w_req_ok, w_eat, w_hit, w_cand_occ;
  logic [1:0]    w_req;
  logic [PW-1:0] w_nh_x, w_nh_y;
  logic [CW-1:0] w_nh_idx, w_tail_idx, w_head_ptr_nx, w_tail_ptr_nx;
  logic [CW-1:0] w_lfsr_red, w_cand_nx;
  logic          w_buf_we;
  logic [CW-1:0] w_buf_waddr, w_buf_wdata;

  assign w_soft_rst = rst || ((r_state == S_OVER) && start);

  assign w_req    = up ? D_UP : (down ? D_DOWN : (left ? D_LEFT : D_RIGHT));
  assign w_req_ok = (up || down || left || right) && (w_req != (r_dir ^ 2'd1));

  // Next head tile with wrap on both axes.
  always_comb begin
    w_nh_x = Head_X;
    w_nh_y = Head_Y;
    case (r_pend)
      D_RIGHT: w_nh_x = (Head_X == LAST_XY) ? PW'(0) : Head_X + PW'(1);
      D_LEFT:  w_nh_x = (Head_X == PW'(0)) ? LAST_XY : Head_X - PW'(1);
      D_UP:    w_nh_y = (Head_Y == PW'(0)) ? LAST_XY : Head_Y - PW'(1);
      default: w_nh_y = (Head_Y == LAST_XY) ? PW'(0) : Head_Y + PW'(1);
    endcase
  end

  assign w_nh_idx      = CW'(w_nh_x) * CW'(GRID_SIZE) + CW'(w_nh_y);
  assign w_tail_idx    = r_buf[r_tail_ptr];
  assign w_eat         = (w_nh_x == Apple_X) && (w_nh_y == Apple_Y);
  assign w_hit         = Cell_Snake_Vector[w_nh_idx] && !((w_nh_idx == w_tail_idx) && !w_eat);
  assign w_head_ptr_nx = (r_head_ptr == LAST_IDX) ? CW'(0) : r_head_ptr + CW'(1);
  assign w_tail_ptr_nx = (r_tail_ptr == LAST_IDX) ? CW'(0) : r_tail_ptr + CW'(1);
  assign w_lfsr_red    = (r_lfsr >= CW'(NUM_CELLS)) ? r_lfsr - CW'(NUM_CELLS) : r_lfsr;
  assign w_cand_occ    = Cell_Snake_Vector[r_cand];
  assign w_cand_nx     = (r_cand == LAST_IDX) ? CW'(0) : r_cand + CW'(1);

  // Next-state logic.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_INIT0:  w_state_nx = S_INIT1;
      S_INIT1:  w_state_nx = S_IDLE;
      S_IDLE:   if (start) w_state_nx = S_RUN;
      S_RUN:    if (move_tick) w_state_nx = S_STEP;
      S_STEP: begin
        if (w_hit)                   w_state_nx = S_OVER;
        else if (!w_eat)             w_state_nx = S_TAILRD;
        else if (r_len == LAST_IDX)  w_state_nx = S_OVER;
        else                         w_state_nx = S_PLACE;
      end
      S_TAILRD: w_state_nx = S_RUN;
      S_PLACE:  if (!w_cand_occ || (r_place_cnt == LAST_IDX)) w_state_nx = S_RUN;
      S_OVER:   if (start) w_state_nx = S_INIT0;
      default:  w_state_nx = S_INIT0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_soft_rst) r_state <= S_INIT0;
    else            r_state <= w_state_nx;
  end

  // Body buffer write port: INIT seeds tail/head, STEP appends the new head.
  always_comb begin
    w_buf_we    = 1'b0;
    w_buf_waddr = '0;
    w_buf_wdata = '0;
    if (!w_soft_rst) begin
      case (r_state)
        S_INIT0: begin w_buf_we = 1'b1; w_buf_waddr = CW'(0); w_buf_wdata = TAIL0_IDX; end
        S_INIT1: begin w_buf_we = 1'b1; w_buf_waddr = CW'(1); w_buf_wdata = HEAD0_IDX; end
        S_STEP:  begin
          w_buf_we    = !w_hit;
          w_buf_waddr = w_head_ptr_nx;
          w_buf_wdata = w_nh_idx;
        end
        default: w_buf_we = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_buf_we) r_buf[w_buf_waddr] <= w_buf_wdata;
  end

  always_ff @(posedge clk) begin
    if (w_soft_rst) begin
      Head_X            <= PW'(START_X);
      Head_Y            <= PW'(START_Y);
      Tail_X            <= PW'(START_X - 1);
      Tail_Y            <= PW'(START_Y);
      Apple_X           <= PW'(APPLE0_X);
      Apple_Y           <= PW'(APPLE0_Y);
      Cell_Snake_Vector <= VEC0;
      score             <= '0;
      game_over         <= 1'b0;
      win               <= 1'b0;
      busy              <= 1'b1;
      r_dir             <= D_RIGHT;
      r_pend            <= D_RIGHT;
      r_len             <= CW'(2);
      r_head_ptr        <= CW'(1);
      r_tail_ptr        <= CW'(0);
      r_lfsr            <= 8'hA5;
      r_cand            <= '0;
      r_place_cnt       <= '0;
    end else begin
      r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
      busy   <= (w_state_nx == S_INIT0) || (w_state_nx == S_INIT1) || (w_state_nx == S_STEP) ||
                (w_state_nx == S_TAILRD) || (w_state_nx == S_PLACE);
      if (((r_state == S_IDLE) || (r_state == S_RUN)) && w_req_ok) r_pend <= w_req;

      case (r_state)
        S_STEP: begin
          if (w_hit) begin
            game_over <= 1'b1;
          end else begin
            r_head_ptr <= w_head_ptr_nx;
            Head_X     <= w_nh_x;
            Head_Y     <= w_nh_y;
            r_dir      <= r_pend;
            if (!w_eat) begin
              // Clear then set, so a head entering the vacating tail cell keeps it set.
              Cell_Snake_Vector[w_tail_idx] <= 1'b0;
              r_tail_ptr <= w_tail_ptr_nx;
            end else begin
              r_len       <= r_len + CW'(1);
              score       <= score + 8'd1;
              r_cand      <= w_lfsr_red;
              r_place_cnt <= '0;
              if (r_len == LAST_IDX) begin
                win       <= 1'b1;
                game_over <= 1'b1;
              end
            end
            Cell_Snake_Vector[w_nh_idx] <= 1'b1;
          end
        end
        S_TAILRD: begin
          Tail_X <= PW'(w_tail_idx / CW'(GRID_SIZE));
          Tail_Y <= PW'(w_tail_idx % CW'(GRID_SIZE));
        end
        S_PLACE: begin
          if (!w_cand_occ) begin
            Apple_X <= PW'(r_cand / CW'(GRID_SIZE));
            Apple_Y <= PW'(r_cand % CW'(GRID_SIZE));
          end else begin
            r_cand      <= w_cand_nx;
            r_place_cnt <= r_place_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_state_engine.sv
// Directed bench for snake_state_engine: tracks the head with a small move model
// and steers onto whatever apple the design places.
module tb_snake_state_engine;

  localparam int DR = 0;
  localparam int DL = 1;
  localparam int DU = 2;
  localparam int DD = 3;

  logic         clk = 1'b0;
  logic         rst, move_tick, start, up, down, left, right;
  logic [3:0]   Head_X, Head_Y, Tail_X, Tail_Y, Apple_X, Apple_Y;
  logic [224:0] Cell_Snake_Vector;
  logic [7:0]   score;
  logic         game_over, win, busy;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  logic [3:0]   m_hx, m_hy;
  int           m_dir, m_pend;
  logic [224:0] ev;
  logic [3:0]   sx, sy, ax, ay;
  int           sq [4];

  always #5 clk = ~clk;

  snake_state_engine dut (
    .clk(clk), .rst(rst), .move_tick(move_tick), .start(start),
    .up(up), .down(down), .left(left), .right(right),
    .Head_X(Head_X), .Head_Y(Head_Y), .Tail_X(Tail_X), .Tail_Y(Tail_Y),
    .Apple_X(Apple_X), .Apple_Y(Apple_Y), .Cell_Snake_Vector(Cell_Snake_Vector),
    .score(score), .game_over(game_over), .win(win), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [224:0] exp);
    n_chk++;
    assert (Cell_Snake_Vector === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, Cell_Snake_Vector, exp);
    end
  endtask

  function automatic logic [3:0] inc(input logic [3:0] v);
    return (v == 4'd14) ? 4'd0 : v + 4'd1;
  endfunction

  function automatic logic [3:0] dec(input logic [3:0] v);
    return (v == 4'd0) ? 4'd14 : v - 4'd1;
  endfunction

  function automatic int opp(input int d);
    case (d)
      DR: return DL;
      DL: return DR;
      DU: return DD;
      default: return DU;
    endcase
  endfunction

  // One cycle of requests (optionally with a tick); live = design is in IDLE/RUN.
  task automatic cyc(input logic u, input logic d, input logic l, input logic r,
                     input bit tk, input bit live, input bit hit);
    int req;
    @(negedge clk);
    up = u; down = d; left = l; right = r; move_tick = tk;
    if (live && (u || d || l || r)) begin
      req = u ? DU : (d ? DD : (l ? DL : DR));
      if (req != opp(m_dir)) m_pend = req;
    end
    @(negedge clk);
    up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0; move_tick = 1'b0;
    if (tk && live && !hit) begin
      case (m_pend)
        DR: m_hx = inc(m_hx);
        DL: m_hx = dec(m_hx);
        DU: m_hy = dec(m_hy);
        default: m_hy = inc(m_hy);
      endcase
      m_dir = m_pend;
    end
    if (tk) begin
      for (int i = 0; i < 230 && busy; i++) @(negedge clk);
      chk("busy_released", busy, 1'b0);
    end
    chk("head_x", Head_X, m_hx);
    chk("head_y", Head_Y, m_hy);
  endtask

  task automatic go(input int d, input bit hit);
    cyc(d == DU, d == DD, d == DL, d == DR, 1'b1, 1'b1, hit);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic model_reset();
    m_hx = 4'd7; m_hy = 4'd7; m_dir = DR; m_pend = DR;
  endtask

  // Ride right to the apple column, then down to its row; eats exactly once.
  task automatic steer();
    ax = Apple_X; ay = Apple_Y;
    for (int i = 0; i < 40 && m_hx != ax; i++) go(DR, 1'b0);
    for (int i = 0; i < 40 && m_hy != ay; i++) go(DD, 1'b0);
  endtask

  task automatic chk_reset_state(input string tag);
    ev = '0; ev[97] = 1'b1; ev[112] = 1'b1;
    chk({tag, "_head_x"}, Head_X, 4'd7);
    chk({tag, "_head_y"}, Head_Y, 4'd7);
    chk({tag, "_tail_x"}, Tail_X, 4'd6);
    chk({tag, "_tail_y"}, Tail_Y, 4'd7);
    chk({tag, "_apple_x"}, Apple_X, 4'd10);
    chk({tag, "_apple_y"}, Apple_Y, 4'd4);
    chk({tag, "_score"}, score, 8'd0);
    chk({tag, "_game_over"}, game_over, 1'b0);
    chk({tag, "_win"}, win, 1'b0);
    chk({tag, "_busy"}, busy, 1'b1);
    chk_vec({tag, "_vector"}, ev);
  endtask

  initial begin
    rst = 1'b1; move_tick = 1'b0; start = 1'b0;
    up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk_reset_state("rst");
    rst = 1'b0;
    @(negedge clk); chk("init_busy", busy, 1'b1);
    @(negedge clk); chk("idle_busy", busy, 1'b0);

    // Tick in IDLE is ignored.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk_vec("idle_tick_vector", ev);

    pulse_start();
    // First move: head updates one cycle after the tick, tail one cycle later.
    @(negedge clk); move_tick = 1'b1;
    @(negedge clk); move_tick = 1'b0;
    chk("lat_step_head", Head_X, 4'd7);
    @(negedge clk);
    chk("lat_head", Head_X, 4'd8);
    chk("lat_tail_old", Tail_X, 4'd6);
    @(negedge clk);
    chk("lat_tail_new", Tail_X, 4'd7);
    chk("lat_busy", busy, 1'b0);
    m_hx = 4'd8;

    repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("run3_tail_x", Tail_X, 4'd9);
    chk("run3_tail_y", Tail_Y, 4'd7);
    chk("run3_score", score, 8'd0);
    ev = '0; ev[142] = 1'b1; ev[157] = 1'b1;
    chk_vec("run3_vector", ev);

    // Right-edge wrap, then top-edge wrap.
    repeat (5) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("wrap_x_head", Head_X, 4'd0);
    chk("wrap_x_tail", Tail_X, 4'd14);
    go(DU, 1'b0);
    repeat (7) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("wrap_y_head_x", Head_X, 4'd0);
    chk("wrap_y_head_y", Head_Y, 4'd14);

    // Reversal ignored; up beats left.
    go(DR, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("reverse_head_x", Head_X, 4'd2);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("prio_head_x", Head_X, 4'd2);
    chk("prio_head_y", Head_Y, 4'd13);

    // Eat the reset apple at (10,4).
    go(DR, 1'b0);
    repeat (7) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    go(DU, 1'b0);
    repeat (8) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("eat_score", score, 8'd1);
    chk("eat_tail_x", Tail_X, 4'd10);
    chk("eat_tail_y", Tail_Y, 4'd6);
    ev = '0; ev[154] = 1'b1; ev[155] = 1'b1; ev[156] = 1'b1;
    chk_vec("eat_vector", ev);
    chk("eat_len", $countones(Cell_Snake_Vector), 3);
    chk("apple_moved", (Apple_X == 4'd10) && (Apple_Y == 4'd4), 1'b0);
    chk("apple_free", Cell_Snake_Vector[Apple_X * 15 + Apple_Y], 1'b0);

    // Grow to length 5, straighten, then fold back into the body.
    steer(); chk("grow_score2", score, 8'd2);
    steer(); chk("grow_score3", score, 8'd3);
    chk("grow_len", $countones(Cell_Snake_Vector), 5);
    chk("pre_hit_over", game_over, 1'b0);
    repeat (4) go(DR, 1'b0);
    go(DD, 1'b0);
    go(DL, 1'b0);
    go(DU, 1'b1);
    chk("hit_over", game_over, 1'b1);
    chk("hit_win", win, 1'b0);
    chk("hit_busy", busy, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("frozen_over", game_over, 1'b1);

    // Restart returns every output to its reset value.
    pulse_start();
    model_reset();
    chk_reset_state("restart");
    @(negedge clk);
    @(negedge clk); chk("restart_idle_busy", busy, 1'b0);

    // Length-4 snake circling a 2x2 square that avoids the apple.
    pulse_start();
    steer(); chk("sq_score1", score, 8'd1);
    steer(); chk("sq_score2", score, 8'd2);
    sx = m_hx; sy = m_hy;
    ax = Apple_X; ay = Apple_Y;
    if (!((ax == inc(sx) && ay == sy) || (ax == inc(sx) && ay == inc(sy)) ||
          (ax == sx && ay == inc(sy)))) begin
      sq = '{DR, DD, DL, DU};
    end else if (!((ax == inc(sx) && ay == sy) || (ax == inc(sx) && ay == dec(sy)) ||
                   (ax == sx && ay == dec(sy)))) begin
      sq = '{DR, DU, DL, DD};
    end else if (m_dir != DU) begin
      sq = '{DD, DL, DU, DR};
    end else begin
      sq = '{DU, DL, DD, DR};
    end
    for (int k = 0; k < 8; k++) go(sq[k % 4], 1'b0);
    chk("sq_back_x", Head_X, sx);
    chk("sq_back_y", Head_Y, sy);
    chk("sq_no_over", game_over, 1'b0);
    chk("sq_len", $countones(Cell_Snake_Vector), 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
